ddr_burst_arbiter: RTL and testbench

DDR_BURST_ARBITER -- requirements
Module: ddr_burst_arbiter

---
 rtl/ddr_burst_arbiter_pkg.sv | 35 +++
 rtl/ddr_burst_arbiter_if.sv | 43 ++++
 rtl/ddr_burst_arbiter_rr_select.sv | 28 ++
 rtl/ddr_burst_arbiter.sv | 157 +++++++++++++++
 tb/tb_ddr_burst_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_burst_arbiter_pkg.sv
// Shared types and defaults for the DDR burst arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ddr_burst_arbiter_pkg;

   // Arbiter FSM encoding; one burst is outstanding from ISSUE until BUSY ends
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2
   } state_t;

   // Default geometry
   localparam int DEF_NUM_REQ = 3;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_LEN_W   = 8;
   localparam int DEF_TIMEOUT = 4095;

   // Channels 0 and 1 carry writes, channel 2 carries reads
   localparam logic [2:0] DEF_WR_MASK = 3'b011;

   // Fixed channel roles
   localparam int CH_WR0 = 0;
   localparam int CH_WR1 = 1;
   localparam int CH_RD  = 2;

   // Width of the command owner id
   localparam int ID_W = 2;

   // Counter width able to hold values 0..max_val
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ddr_burst_arbiter_if.sv
// Requester + memory-controller command bundle for the burst arbiter.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready handshake on the command side; req is a held level.
interface ddr_burst_arbiter_if
   import ddr_burst_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int LEN_W   = DEF_LEN_W
);
   // Requester side
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*LEN_W-1:0]  req_len;
   logic                      rd_urgent;
   logic [NUM_REQ-1:0]        gnt;

   // Memory-controller side
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic [ADDR_W-1:0]         cmd_addr;
   logic [LEN_W-1:0]          cmd_len;
   logic                      cmd_wr;
   logic [ID_W-1:0]           cmd_id;
   logic                      cmd_done;

   // Status
   logic                      busy;
   logic                      timeout_err;

   // Arbiter view
   modport master (
      input  req, req_addr, req_len, rd_urgent, cmd_ready, cmd_done,
      output gnt, cmd_valid, cmd_addr, cmd_len, cmd_wr, cmd_id, busy, timeout_err
   );

   // Environment view (requesters and memory controller)
   modport slave (
      output req, req_addr, req_len, rd_urgent, cmd_ready, cmd_done,
      input  gnt, cmd_valid, cmd_addr, cmd_len, cmd_wr, cmd_id, busy, timeout_err
   );

endinterface

// File: rtl/ddr_burst_arbiter_rr_select.sv
// Round-robin priority selector: first requester strictly after the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; o_vld low when no request is present.
module rr_select #(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_win,
   output logic               o_vld
);

   // Walk offsets 1..NUM_REQ from the pointer; the first live request wins
   always_comb begin
      o_win = '0;
      o_vld = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_vld && i_req[i] && (i == ((int'(i_ptr) + k) % NUM_REQ))) begin
               o_win[i] = 1'b1;
               o_vld    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Arbitrates burst requests from write/read channels onto a single memory command port.
// Latency: req seen in IDLE -> cmd_valid next cycle; gnt pulses in the cmd_valid&&cmd_ready cycle.
// Backpressure: cmd_* held stable while cmd_ready is low; one burst outstanding until cmd_done or timeout.
module ddr_burst_arbiter
   import ddr_burst_arbiter_pkg::*;
#(
   parameter int               NUM_REQ = DEF_NUM_REQ,
   parameter int               ADDR_W  = DEF_ADDR_W,
   parameter int               LEN_W   = DEF_LEN_W,
   parameter logic [NUM_REQ-1:0] WR_MASK = DEF_WR_MASK,
   parameter int               TIMEOUT = DEF_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   ddr_burst_arbiter_if.master io_bus
);

   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TCNT_W = cnt_width(TIMEOUT);

   // FSM and registered outputs
   state_t              r_state;
   logic [PTR_W-1:0]    r_ptr;
   logic                r_cmd_valid;
   logic [ADDR_W-1:0]   r_addr;
   logic [LEN_W-1:0]    r_len;
   logic                r_wr;
   logic [ID_W-1:0]     r_id;
   logic                r_busy;
   logic                r_timeout_err;
   logic [TCNT_W-1:0]   r_tcnt;

   // Arbitration wires
   logic [NUM_REQ-1:0]  w_rr_win;
   logic                w_rr_vld;
   logic                w_urg;
   logic [NUM_REQ-1:0]  w_win;
   logic                w_any;
   logic [PTR_W-1:0]    w_win_idx;
   logic [ADDR_W-1:0]   w_win_addr;
   logic [LEN_W-1:0]    w_win_len;
   logic                w_win_wr;
   logic                w_accept;
   logic [NUM_REQ-1:0]  w_gnt;

   rr_select #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_select (
      .i_req (io_bus.req),
      .i_ptr (r_ptr),
      .o_win (w_rr_win),
      .o_vld (w_rr_vld)
   );

   // Urgent read overrides round-robin; otherwise take the rotating winner
   always_comb begin
      w_urg = io_bus.rd_urgent && io_bus.req[CH_RD];
      w_win = w_urg ? (NUM_REQ'(1) << CH_RD) : w_rr_win;
      w_any = w_urg || w_rr_vld;
   end

   // One-hot mux of the winning channel's index, address, length and direction
   always_comb begin
      w_win_idx  = '0;
      w_win_addr = '0;
      w_win_len  = '0;
      w_win_wr   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win[i]) begin
            w_win_idx  = PTR_W'(i);
            w_win_addr = io_bus.req_addr[i*ADDR_W +: ADDR_W];
            w_win_len  = io_bus.req_len[i*LEN_W +: LEN_W];
            w_win_wr   = WR_MASK[i];
         end
      end
   end

   // Grant must coincide with the accepting handshake, so it is decoded from registered state
   always_comb begin
      w_accept = (r_state == ST_ISSUE) && io_bus.cmd_ready;
      w_gnt    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_gnt[i] = w_accept && (r_id == ID_W'(i));
      end
   end

   // Arbiter FSM: latch winner in IDLE, present in ISSUE, wait for completion or timeout in BUSY
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_ptr         <= PTR_W'(NUM_REQ - 1);
         r_cmd_valid   <= 1'b0;
         r_addr        <= '0;
         r_len         <= '0;
         r_wr          <= 1'b0;
         r_id          <= '0;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_tcnt        <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_state     <= ST_ISSUE;
                  r_cmd_valid <= 1'b1;
                  r_busy      <= 1'b1;
                  r_addr      <= w_win_addr;
                  r_len       <= w_win_len;
                  r_wr        <= w_win_wr;
                  r_id        <= ID_W'(w_win_idx);
                  // Urgent reads jump the queue without disturbing the rotation
                  if (!w_urg) begin
                     r_ptr <= w_win_idx;
                  end
               end
            end
            ST_ISSUE: begin
               // Requester may drop req here; the latched command still goes out
               if (io_bus.cmd_ready) begin
                  r_state     <= ST_BUSY;
                  r_cmd_valid <= 1'b0;
                  r_tcnt      <= '0;
               end
            end
            ST_BUSY: begin
               if (io_bus.cmd_done) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (r_tcnt == TCNT_W'(TIMEOUT - 1)) begin
                  // Controller never completed: abandon the burst and flag it
                  r_state       <= ST_IDLE;
                  r_busy        <= 1'b0;
                  r_timeout_err <= 1'b1;
               end else begin
                  r_tcnt <= r_tcnt + TCNT_W'(1);
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cmd_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign io_bus.gnt         = w_gnt;
   assign io_bus.cmd_valid   = r_cmd_valid;
   assign io_bus.cmd_addr    = r_addr;
   assign io_bus.cmd_len     = r_len;
   assign io_bus.cmd_wr      = r_wr;
   assign io_bus.cmd_id      = r_id;
   assign io_bus.busy        = r_busy;
   assign io_bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Self-checking bench for ddr_burst_arbiter with a queue-free arbitration model.
// Latency: n/a.
// Backpressure: bench drives cmd_ready/cmd_done with fixed and random delays.
module tb_ddr_burst_arbiter;
   import ddr_burst_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ddr_burst_arbiter_if #(.NUM_REQ(3), .ADDR_W(32), .LEN_W(8)) bus ();

   ddr_burst_arbiter #(
      .NUM_REQ (3),
      .ADDR_W  (32),
      .LEN_W   (8),
      .WR_MASK (3'b011),
      .TIMEOUT (15)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   typedef struct {
      logic        vld1;
      logic [1:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic        wr;
      logic        stable;
      logic [2:0]  gnt;
      logic        vld_busy;
      logic        busy_after;
      int          pulses;
   } obs_t;

   int n_cmp = 0;
   int n_bad = 0;
   int gnt_pulses = 0;
   int last_ch = 2;
   logic [31:0] ch_addr [3];
   logic [7:0]  ch_len  [3];

   // Count cycles in which any grant is asserted
   always begin
      @(negedge clk);
      #2;
      if ((|bus.gnt) === 1'b1) gnt_pulses++;
   end

   // Reference arbitration: urgent read first, else next requester after the last normal winner
   function automatic int pick(input logic [2:0] r, input logic u);
      int c;
      if (u && r[2]) return 2;
      for (int k = 1; k <= 3; k++) begin
         c = (last_ch + k) % 3;
         if (r[c[1:0]]) return c;
      end
      return -1;
   endfunction

   function automatic logic [42:0] exp_fields(input int e);
      return {(e != 2), ch_len[e[1:0]], ch_addr[e[1:0]], e[1:0]};
   endfunction

   task automatic new_addrs();
      for (int i = 0; i < 3; i++) begin
         ch_addr[i] = $urandom;
         ch_len[i]  = 8'($urandom);
      end
      bus.req_addr = {ch_addr[2], ch_addr[1], ch_addr[0]};
      bus.req_len  = {ch_len[2], ch_len[1], ch_len[0]};
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.req = '0; bus.rd_urgent = 1'b0; bus.cmd_ready = 1'b0; bus.cmd_done = 1'b0;
      bus.req_addr = '0; bus.req_len = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      last_ch = 2;
   endtask

   // Drive one burst from an IDLE negedge through completion; returns observations only
   task automatic run_burst(input logic [2:0] reqv, input logic urg, input int rdy_dly,
                            input int done_dly, input bit drop, output obs_t o);
      int p0;
      p0 = gnt_pulses;
      bus.req = reqv; bus.rd_urgent = urg; bus.cmd_ready = (rdy_dly == 0);
      @(negedge clk);
      o.vld1 = bus.cmd_valid; o.id = bus.cmd_id; o.addr = bus.cmd_addr;
      o.len = bus.cmd_len; o.wr = bus.cmd_wr; o.stable = 1'b1;
      if (drop) bus.req = '0;
      for (int i = 0; i < rdy_dly; i++) begin
         bus.cmd_done = drop;
         @(negedge clk);
         if (bus.cmd_valid !== 1'b1 || bus.cmd_addr !== o.addr || bus.cmd_len !== o.len ||
             bus.cmd_id !== o.id || bus.gnt !== 3'b000 || bus.busy !== 1'b1) o.stable = 1'b0;
      end
      bus.cmd_done = 1'b0;
      bus.cmd_ready = 1'b1;
      #1;
      o.gnt = bus.gnt;
      @(negedge clk);
      bus.cmd_ready = 1'b0;
      o.vld_busy = bus.cmd_valid;
      for (int i = 0; i < done_dly; i++) @(negedge clk);
      bus.cmd_done = 1'b1;
      @(negedge clk);
      bus.cmd_done = 1'b0;
      o.busy_after = bus.busy;
      o.pulses = gnt_pulses - p0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++; if (bus.gnt !== 3'b000) begin n_bad++; $display("FAIL reset_gnt: got %b want 000", bus.gnt); end
      n_cmp++; if (bus.cmd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_valid: got %b want 0", bus.cmd_valid); end
      n_cmp++; if ({bus.cmd_wr, bus.cmd_len, bus.cmd_addr, bus.cmd_id} !== 43'd0) begin n_bad++;
         $display("FAIL reset_cmd_fields: got wr=%b len=%0d addr=%h id=%0d want all 0", bus.cmd_wr, bus.cmd_len, bus.cmd_addr, bus.cmd_id); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_timeout_err: got %b want 0", bus.timeout_err); end
   endtask

   task automatic test_single();
      obs_t o;
      ch_addr[0] = 32'h0000_1000; ch_len[0] = 8'd15;
      bus.req_addr = {ch_addr[2], ch_addr[1], ch_addr[0]};
      bus.req_len  = {ch_len[2], ch_len[1], ch_len[0]};
      run_burst(3'b001, 1'b0, 0, 2, 1'b0, o);
      bus.req = '0;
      last_ch = 0;
      n_cmp++; if (o.vld1 !== 1'b1) begin n_bad++; $display("FAIL single_latency: cmd_valid got %b want 1", o.vld1); end
      n_cmp++; if (o.gnt !== 3'b001) begin n_bad++; $display("FAIL single_gnt: got %b want 001", o.gnt); end
      n_cmp++; if ({o.wr, o.len, o.addr, o.id} !== {1'b1, 8'd15, 32'h0000_1000, 2'd0}) begin n_bad++;
         $display("FAIL single_cmd: got wr=%b len=%0d addr=%h id=%0d want wr=1 len=15 addr=00001000 id=0", o.wr, o.len, o.addr, o.id); end
      n_cmp++; if (o.vld_busy !== 1'b0) begin n_bad++; $display("FAIL single_valid_in_busy: got %b want 0", o.vld_busy); end
      n_cmp++; if (o.busy_after !== 1'b0) begin n_bad++; $display("FAIL single_idle_after_done: busy got %b want 0", o.busy_after); end
   endtask

   task automatic test_round_robin();
      obs_t o;
      int e;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         new_addrs();
         e = pick(3'b111, 1'b0);
         run_burst(3'b111, 1'b0, 0, 3, 1'b0, o);
         last_ch = e;
         n_cmp++; if (o.gnt !== (3'b001 << e)) begin n_bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, o.gnt, 3'b001 << e); end
         n_cmp++; if ({o.wr, o.len, o.addr, o.id} !== exp_fields(e)) begin n_bad++;
            $display("FAIL rr_cmd[%0d]: got %h want %h", i, {o.wr, o.len, o.addr, o.id}, exp_fields(e)); end
      end
      bus.req = '0;
   endtask

   task automatic test_urgent();
      obs_t o;
      int e;
      logic u;
      for (int i = 0; i < 3; i++) begin
         u = (i == 1);
         new_addrs();
         e = pick(3'b111, u);
         run_burst(3'b111, u, 0, 1, 1'b0, o);
         if (!u) last_ch = e;
         n_cmp++; if (o.gnt !== (3'b001 << e)) begin n_bad++; $display("FAIL urgent_gnt[%0d]: got %b want %b", i, o.gnt, 3'b001 << e); end
      end
      bus.req = '0; bus.rd_urgent = 1'b0;
   endtask

   task automatic test_backpressure();
      obs_t o;
      int e;
      new_addrs();
      e = pick(3'b011, 1'b0);
      run_burst(3'b011, 1'b0, 10, 1, 1'b0, o);
      bus.req = '0;
      last_ch = e;
      n_cmp++; if (o.stable !== 1'b1) begin n_bad++; $display("FAIL bp_stable: got %b want 1", o.stable); end
      n_cmp++; if (o.gnt !== (3'b001 << e)) begin n_bad++; $display("FAIL bp_gnt: got %b want %b", o.gnt, 3'b001 << e); end
      n_cmp++; if (o.pulses != 1) begin n_bad++; $display("FAIL bp_gnt_pulses: got %0d want 1", o.pulses); end
      n_cmp++; if ({o.wr, o.len, o.addr, o.id} !== exp_fields(e)) begin n_bad++;
         $display("FAIL bp_cmd: got %h want %h", {o.wr, o.len, o.addr, o.id}, exp_fields(e)); end
   endtask

   task automatic test_drop_in_issue();
      obs_t o;
      int e;
      new_addrs();
      e = pick(3'b110, 1'b0);
      run_burst(3'b110, 1'b0, 3, 2, 1'b1, o);
      bus.req = '0;
      last_ch = e;
      n_cmp++; if (o.stable !== 1'b1) begin n_bad++; $display("FAIL drop_cmd_held: got %b want 1", o.stable); end
      n_cmp++; if (o.gnt !== (3'b001 << e)) begin n_bad++; $display("FAIL drop_gnt: got %b want %b", o.gnt, 3'b001 << e); end
      n_cmp++; if (o.busy_after !== 1'b0) begin n_bad++; $display("FAIL drop_completes: busy got %b want 0", o.busy_after); end
   endtask

   task automatic test_random();
      obs_t o;
      int e;
      logic [2:0] pend;
      logic u;
      pend = '0;
      for (int i = 0; i < 40; i++) begin
         pend = pend | 3'($urandom);
         if (pend == 3'b000) pend = 3'b001 << $urandom_range(0, 2);
         u = ($urandom_range(0, 3) == 0);
         new_addrs();
         e = pick(pend, u);
         run_burst(pend, u, $urandom_range(0, 3), $urandom_range(0, 5), 1'b0, o);
         if (!(u && pend[2])) last_ch = e;
         n_cmp++; if (o.vld1 !== 1'b1 || o.gnt !== (3'b001 << e)) begin n_bad++;
            $display("FAIL rand_gnt[%0d]: req=%b urg=%b valid=%b gnt=%b want valid=1 gnt=%b", i, pend, u, o.vld1, o.gnt, 3'b001 << e); end
         n_cmp++; if ({o.wr, o.len, o.addr, o.id} !== exp_fields(e) || o.pulses != 1) begin n_bad++;
            $display("FAIL rand_cmd[%0d]: got %h pulses=%0d want %h pulses=1", i, {o.wr, o.len, o.addr, o.id}, o.pulses, exp_fields(e)); end
         pend = pend & ~(3'b001 << e);
      end
      bus.req = '0; bus.rd_urgent = 1'b0;
   endtask

   task automatic test_timeout();
      obs_t o;
      int e;
      new_addrs();
      e = pick(3'b010, 1'b0);
      bus.req = 3'b010; bus.cmd_ready = 1'b1;
      @(negedge clk);
      last_ch = e;
      bus.req = '0;
      @(negedge clk);
      bus.cmd_ready = 1'b0;
      for (int i = 1; i < 15; i++) @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0) begin n_bad++;
         $display("FAIL timeout_early: busy=%b err=%b want busy=1 err=0", bus.busy, bus.timeout_err); end
      @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b1) begin n_bad++;
         $display("FAIL timeout_fire: busy=%b err=%b want busy=0 err=1", bus.busy, bus.timeout_err); end
      new_addrs();
      e = pick(3'b100, 1'b0);
      run_burst(3'b100, 1'b0, 0, 1, 1'b0, o);
      bus.req = '0;
      last_ch = e;
      n_cmp++; if (o.gnt !== (3'b001 << e) || bus.timeout_err !== 1'b1) begin n_bad++;
         $display("FAIL timeout_next: gnt=%b err=%b want gnt=%b err=1", o.gnt, bus.timeout_err, 3'b001 << e); end
   endtask

   task automatic test_reset_mid_burst();
      obs_t o;
      new_addrs();
      bus.req = 3'b111; bus.rd_urgent = 1'b0; bus.cmd_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.cmd_ready = 1'b0;
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_busy: got %b want 1", bus.busy); end
      rst = 1'b1;
      #1;
      n_cmp++; if ({bus.gnt, bus.cmd_valid, bus.busy, bus.timeout_err} !== 6'd0 ||
                   {bus.cmd_wr, bus.cmd_len, bus.cmd_addr, bus.cmd_id} !== 43'd0) begin n_bad++;
         $display("FAIL midrst_async: gnt=%b valid=%b busy=%b err=%b fields=%h want all 0",
                  bus.gnt, bus.cmd_valid, bus.busy, bus.timeout_err, {bus.cmd_wr, bus.cmd_len, bus.cmd_addr, bus.cmd_id}); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      last_ch = 2;
      run_burst(3'b111, 1'b0, 0, 1, 1'b0, o);
      bus.req = '0;
      n_cmp++; if (o.gnt !== 3'b001) begin n_bad++; $display("FAIL midrst_first_gnt: got %b want 001", o.gnt); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.req = '0; bus.rd_urgent = 1'b0; bus.cmd_ready = 1'b0; bus.cmd_done = 1'b0;
      bus.req_addr = '0; bus.req_len = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_urgent();
      test_backpressure();
      test_drop_in_issue();
      test_random();
      test_timeout();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
